// File: rtl/usbf_dma_pkg.sv
// Shared types and widths for the USB function DMA request arbiter.
// Imported by the round-robin picker and the arbiter top.
package usbf_dma_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int EP_IDX_W = 4;
    localparam int BURST_W  = 8;

endpackage

// File: rtl/usbf_rr_pick.sv
// Combinational round-robin picker: rotate so the search starts just
// after the last winner, take the lowest set bit, rotate the index back.
module usbf_rr_pick
    import usbf_dma_pkg::*;
#(
    parameter int NUM_EP = 16
) (
    input  logic [NUM_EP-1:0]   req,
    input  logic [EP_IDX_W-1:0] last,
    output logic                valid,
    output logic [NUM_EP-1:0]   pick_oh,
    output logic [EP_IDX_W-1:0] pick_idx
);

    logic [2*NUM_EP-1:0] dbl;
    logic [NUM_EP-1:0]   rot;
    int                  start;
    int                  pos;
    int                  idx;

    always_comb begin
        start = (int'(last) + 1) % NUM_EP;
        dbl   = {req, req} >> start;
        rot   = dbl[NUM_EP-1:0];
        pos   = 0;
        for (int i = NUM_EP - 1; i >= 0; i--) begin
            if (rot[i]) pos = i;
        end
        idx      = (start + pos) % NUM_EP;
        valid    = |rot;
        pick_idx = EP_IDX_W'(idx);
        pick_oh  = valid ? (NUM_EP'(1) << idx) : '0;
    end

endmodule

// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter funnelling endpoint DMA requests into one
// system DMA request, with per-endpoint ack steering and burst limit.
module usbf_dma_arb
    import usbf_dma_pkg::*;
#(
    parameter int NUM_EP    = 16,
    parameter int MAX_BURST = 8,
    parameter int GAP       = 1
) (
    input  logic                wclk,
    input  logic                rst,
    input  logic [NUM_EP-1:0]   ep_dma_req,
    input  logic [NUM_EP-1:0]   ep_en,
    output logic [NUM_EP-1:0]   ep_dma_ack,
    output logic                dma_req,
    output logic [EP_IDX_W-1:0] dma_ep,
    input  logic                dma_ack,
    output logic                dma_err,
    output logic                busy
);

    localparam logic [BURST_W-1:0]  BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [1:0]          GAP_END   = 2'(GAP - 1);
    localparam logic [EP_IDX_W-1:0] LAST_RST  = EP_IDX_W'(NUM_EP - 1);

    state_t                state_q, state_d;
    logic [EP_IDX_W-1:0]   grant_q, grant_d;
    logic [NUM_EP-1:0]     oh_q, oh_d;
    logic [EP_IDX_W-1:0]   last_q, last_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic [1:0]            gap_q, gap_d;
    logic                  err_q, err_d;

    logic                  pick_valid;
    logic [NUM_EP-1:0]     pick_oh;
    logic [EP_IDX_W-1:0]   pick_idx;
    logic                  cur_ok;
    logic                  room;
    logic                  live;

    usbf_rr_pick #(
        .NUM_EP (NUM_EP)
    ) u_pick (
        .req      (ep_dma_req & ep_en),
        .last     (last_q),
        .valid    (pick_valid),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

    // One-hot grant select avoids out-of-range indexing when NUM_EP < 16.
    assign cur_ok = |(oh_q & ep_dma_req & ep_en);
    assign room   = burst_q != BURST_MAX;
    assign live   = (state_q == GRANT) && cur_ok && room;

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            oh_q    <= '0;
            last_q  <= LAST_RST;
            burst_q <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            oh_q    <= oh_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        oh_d    = oh_q;
        last_d  = last_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        err_d   = dma_ack & ~live;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    grant_d = pick_idx;
                    oh_d    = pick_oh;
                    burst_d = '0;
                end
            end
            GRANT: begin
                if (dma_ack && live) burst_d = burst_q + BURST_W'(1);
                if (!cur_ok || !room) begin
                    state_d = RELEASE;
                    last_d  = grant_q;
                    gap_d   = '0;
                end
            end
            RELEASE: begin
                gap_d = gap_q + 2'd1;
                if (gap_q == GAP_END) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dma_req    = live;
        dma_ep     = (state_q == GRANT) ? grant_q : '0;
        ep_dma_ack = oh_q & {NUM_EP{dma_ack & live}};
        dma_err    = err_q;
        busy       = state_q != IDLE;
    end

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Self-checking bench for usbf_dma_arb: table vectors, directed
// corner sequences and random traffic against a behavioural model.
module tb_usbf_dma_arb;

    localparam int NEP  = 16;
    localparam int MAXB = 8;
    localparam int GAPC = 1;

    logic        wclk = 1'b0;
    logic        rst  = 1'b0;
    logic [15:0] req_i = '0;
    logic [15:0] en_i  = '0;
    logic        ack_i = 1'b0;
    logic [15:0] ep_ack;
    logic        dma_req;
    logic [3:0]  dma_ep;
    logic        dma_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    int m_phase, m_g, m_last, m_cnt, m_gap;
    bit m_err;

    logic        obs_req, obs_err, obs_busy;
    logic [3:0]  obs_ep;
    logic [15:0] obs_ack;

    int g_eps[$];
    int g_acks[$];

    always #5 wclk = ~wclk;

    usbf_dma_arb #(
        .NUM_EP    (NEP),
        .MAX_BURST (MAXB),
        .GAP       (GAPC)
    ) dut (
        .wclk       (wclk),
        .rst        (rst),
        .ep_dma_req (req_i),
        .ep_en      (en_i),
        .ep_dma_ack (ep_ack),
        .dma_req    (dma_req),
        .dma_ep     (dma_ep),
        .dma_ack    (ack_i),
        .dma_err    (dma_err),
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_g     = 0;
        m_last  = NEP - 1;
        m_cnt   = 0;
        m_gap   = 0;
        m_err   = 0;
    endtask

    // One clock: drive inputs, check model at negedge, advance model at posedge.
    task automatic tick(input logic [15:0] rq, input logic [15:0] en, input logic ak);
        bit          mreq;
        bit          ext;
        bit          found;
        logic [15:0] mack;
        logic [15:0] elig;
        int          c;
        req_i = rq;
        en_i  = en;
        ack_i = ak;
        @(negedge wclk);
        mreq = (m_phase == 1) && rq[m_g] && en[m_g] && (m_cnt < MAXB);
        mack = (mreq && ak) ? (16'd1 << m_g) : 16'd0;
        chk("m_dma_req", 32'(dma_req), 32'(mreq));
        chk("m_ep_ack", 32'(ep_ack), 32'(mack));
        chk("m_busy", 32'(busy), 32'(m_phase != 0));
        chk("m_err", 32'(dma_err), 32'(m_err));
        if (m_phase == 1) chk("m_dma_ep", 32'(dma_ep), 32'(m_g));
        obs_req  = dma_req;
        obs_ep   = dma_ep;
        obs_ack  = ep_ack;
        obs_busy = busy;
        obs_err  = dma_err;
        @(posedge wclk);
        m_err = ak && !mreq;
        elig  = rq & en;
        case (m_phase)
            0: begin
                if (elig != 0) begin
                    found = 0;
                    for (int k = 1; k <= NEP; k++) begin
                        c = (m_last + k) % NEP;
                        if (!found && elig[c]) begin
                            m_g   = c;
                            found = 1;
                        end
                    end
                    m_cnt   = 0;
                    m_phase = 1;
                end
            end
            1: begin
                ext = !(rq[m_g] && en[m_g]) || (m_cnt == MAXB);
                if (mreq && ak) m_cnt++;
                if (ext) begin
                    m_phase = 2;
                    m_last  = m_g;
                    m_gap   = GAPC;
                end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) m_phase = 0;
            end
        endcase
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        rst = 1'b1;
    endtask

    // Hold requests and ack every cycle, logging each grant and its ack count.
    task automatic run_grants(input logic [15:0] rq, input int ncyc);
        logic prev;
        g_eps.delete();
        g_acks.delete();
        prev = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            tick(rq, 16'hFFFF, 1'b1);
            if (obs_req && !prev) begin
                g_eps.push_back(int'(obs_ep));
                g_acks.push_back(0);
            end
            if (obs_req) g_acks[g_acks.size() - 1]++;
            prev = obs_req;
        end
    endtask

    typedef struct {
        logic [15:0] rq;
        logic [15:0] en;
        logic        ak;
        logic        x_req;
        logic [3:0]  x_ep;
        logic [15:0] x_ack;
        logic        x_busy;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [15:0] rr;
        logic [15:0] re;
        int          hits;

        vt[0] = '{16'h0004, 16'hFFFF, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0};
        vt[1] = '{16'h0004, 16'hFFFF, 1'b1, 1'b1, 4'd2, 16'h0004, 1'b1};
        vt[2] = '{16'h0004, 16'hFFFF, 1'b1, 1'b1, 4'd2, 16'h0004, 1'b1};
        vt[3] = '{16'h0004, 16'hFFFF, 1'b1, 1'b1, 4'd2, 16'h0004, 1'b1};
        vt[4] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1};
        vt[5] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1};
        vt[6] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0};

        model_reset();
        #2;
        chk("rst_dma_req", 32'(dma_req), 32'd0);
        chk("rst_dma_ep", 32'(dma_ep), 32'd0);
        chk("rst_ep_ack", 32'(ep_ack), 32'd0);
        chk("rst_err", 32'(dma_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            tick(vt[i].rq, vt[i].en, vt[i].ak);
            chk($sformatf("vec%0d_req", i), 32'(obs_req), 32'(vt[i].x_req));
            chk($sformatf("vec%0d_ack", i), 32'(obs_ack), 32'(vt[i].x_ack));
            chk($sformatf("vec%0d_busy", i), 32'(obs_busy), 32'(vt[i].x_busy));
            if (vt[i].x_req) chk($sformatf("vec%0d_ep", i), 32'(obs_ep), 32'(vt[i].x_ep));
        end

        do_reset();
        run_grants(16'h0009, 32);
        chk("rr_ngrants", 32'(g_eps.size()), 32'd3);
        if (g_eps.size() >= 3) begin
            chk("rr_g0", 32'(g_eps[0]), 32'd0);
            chk("rr_g1", 32'(g_eps[1]), 32'd3);
            chk("rr_g2", 32'(g_eps[2]), 32'd0);
            chk("rr_b0", 32'(g_acks[0]), 32'(MAXB));
            chk("rr_b1", 32'(g_acks[1]), 32'(MAXB));
        end
        repeat (6) tick(16'h0000, 16'hFFFF, 1'b0);

        do_reset();
        run_grants(16'h8001, 22);
        chk("wrap_ngrants", 32'(g_eps.size()), 32'd2);
        if (g_eps.size() >= 2) begin
            chk("wrap_g0", 32'(g_eps[0]), 32'd0);
            chk("wrap_g1", 32'(g_eps[1]), 32'd15);
        end
        repeat (6) tick(16'h0000, 16'hFFFF, 1'b0);

        tick(16'h0000, 16'hFFFF, 1'b1);
        chk("stray_ack", 32'(obs_ack), 32'd0);
        tick(16'h0000, 16'hFFFF, 1'b0);
        chk("stray_err", 32'(obs_err), 32'd1);
        chk("stray_idle", 32'(obs_busy), 32'd0);
        tick(16'h0000, 16'hFFFF, 1'b0);
        chk("stray_err_clr", 32'(obs_err), 32'd0);

        tick(16'h0020, 16'hFFFF, 1'b0);
        tick(16'h0020, 16'hFFFF, 1'b1);
        chk("mask_ep", 32'(obs_ep), 32'd5);
        tick(16'h0020, 16'hFFFF, 1'b1);
        tick(16'h0020, 16'hFFDF, 1'b1);
        chk("mask_req_drop", 32'(obs_req), 32'd0);
        chk("mask_ack_drop", 32'(obs_ack), 32'd0);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            tick(16'h0020, 16'hFFDF, 1'b0);
            if (obs_req) hits++;
        end
        chk("mask_no_regrant", 32'(hits), 32'd0);
        chk("mask_idle", 32'(obs_busy), 32'd0);

        tick(16'h0010, 16'hFFFF, 1'b0);
        tick(16'h0010, 16'hFFFF, 1'b1);
        chk("ar_granted", 32'(obs_req), 32'd1);
        ack_i = 1'b1;
        @(negedge wclk);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_dma_req", 32'(dma_req), 32'd0);
        chk("ar_dma_ep", 32'(dma_ep), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ep_ack", 32'(ep_ack), 32'd0);
        ack_i = 1'b0;
        model_reset();
        @(posedge wclk);
        #1;
        rst = 1'b1;
        run_grants(16'h0011, 4);
        chk("ar_first_grant", 32'(g_eps.size() > 0 ? g_eps[0] : 99), 32'd0);
        repeat (14) tick(16'h0000, 16'hFFFF, 1'b0);

        rr = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rr = rr ^ (16'd1 << $urandom_range(0, 15));
            re = ($urandom_range(0, 15) == 0) ? ~(16'd1 << $urandom_range(0, 15)) : 16'hFFFF;
            tick(rr, re, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
